// File: rtl/sbox_layer_ctrl_pkg.sv
// Shared widths and FSM state type for the Midori64 masked S-box layer sequencer.
package sbox_layer_ctrl_pkg;
    localparam int unsigned SLICE_W = 8;
    localparam int unsigned RND_W   = 72;
    localparam int unsigned STATE_W = 64;
    localparam int unsigned NSLICE  = 8;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/sbox_layer_ctrl_share_shift_reg.sv
// 64-bit share register with parallel load and right shift by one byte slice.
// The top byte is refilled either from i_in_byte or from its own old top byte (SELF_FILL).
module share_shift_reg
    import sbox_layer_ctrl_pkg::*;
#(
    parameter int unsigned OUT_LSB   = 0,
    parameter int unsigned OUT_W     = STATE_W,
    parameter bit          SELF_FILL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [STATE_W-1:0] i_load_val,
    input  logic               i_shift,
    input  logic [SLICE_W-1:0] i_in_byte,
    output logic [OUT_W-1:0]   o_q
);
    logic [STATE_W-1:0] r_q;
    logic [SLICE_W-1:0] w_fill;

    assign w_fill = SELF_FILL ? r_q[STATE_W-1 -: SLICE_W] : i_in_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= {w_fill, r_q[STATE_W-1:SLICE_W]};
        end
    end

    // Only the window the parent actually consumes is exported.
    assign o_q = r_q[OUT_LSB +: OUT_W];
endmodule

// File: rtl/sbox_layer_ctrl.sv
// Sequences one 3-share Midori64 S-box layer through an external two-nibble S-box pair.
// Optional macro SBCTRL_SHARE_CLEAR_EN: zero consumed share bytes, idle sb_in* and used results.
module sbox_layer_ctrl
    import sbox_layer_ctrl_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic [STATE_W-1:0] st_in1,
    input  logic [STATE_W-1:0] st_in2,
    input  logic [STATE_W-1:0] st_in3,
    output logic [STATE_W-1:0] st_out1,
    output logic [STATE_W-1:0] st_out2,
    output logic [STATE_W-1:0] st_out3,
    input  logic [RND_W-1:0]   rnd,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    output logic [SLICE_W-1:0] sb_in1,
    output logic [SLICE_W-1:0] sb_in2,
    output logic [SLICE_W-1:0] sb_in3,
    output logic [RND_W-1:0]   sb_r,
    input  logic [SLICE_W-1:0] sb_out1,
    input  logic [SLICE_W-1:0] sb_out2,
    input  logic [SLICE_W-1:0] sb_out3
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);
    localparam int unsigned      RHI_W = STATE_W - SLICE_W;

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_iss, r_col;
    // Bit 0 is aligned with sb_in*, so the tail bit lines up with sb_out* SBOX_LAT cycles later.
    logic [SBOX_LAT:0]  r_vpipe;
    logic               w_start_acc, w_xfer, w_collect, w_last_col, w_res_clr;
    logic [SLICE_W-1:0] w_lo1, w_lo2, w_lo3;
    logic [RHI_W-1:0]   w_rhi1, w_rhi2, w_rhi3;

`ifdef SBCTRL_SHARE_CLEAR_EN
    localparam bit IN_SELF_FILL = 1'b0;
    assign w_res_clr = (r_state == DONE);
`else
    localparam bit IN_SELF_FILL = 1'b1;
    assign w_res_clr = 1'b0;
`endif

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_xfer      = (r_state == FEED) && rnd_valid;
    assign w_collect   = r_vpipe[SBOX_LAT];
    assign w_last_col  = w_collect && (r_col == LAST);

    always_comb begin
        w_state_nx = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        rnd_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nx = FEED;
            end
            FEED: begin
                busy      = 1'b1;
                rnd_ready = 1'b1;
                if (w_xfer && (r_iss == LAST)) w_state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_last_col) w_state_nx = DONE;
            end
            DONE: begin
                done       = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_iss   <= '0;
            r_col   <= '0;
            r_vpipe <= '0;
            sb_in1  <= '0;
            sb_in2  <= '0;
            sb_in3  <= '0;
            sb_r    <= '0;
            st_out1 <= '0;
            st_out2 <= '0;
            st_out3 <= '0;
        end else begin
            r_state <= w_state_nx;
            r_vpipe <= {r_vpipe[SBOX_LAT-1:0], w_xfer};
            if (w_start_acc) begin
                r_iss <= '0;
                r_col <= '0;
            end
            if (w_xfer) begin
                r_iss  <= r_iss + CNT_W'(1);
                sb_in1 <= w_lo1;
                sb_in2 <= w_lo2;
                sb_in3 <= w_lo3;
                sb_r   <= rnd;
            end else begin
                sb_r <= '0;
`ifdef SBCTRL_SHARE_CLEAR_EN
                sb_in1 <= '0;
                sb_in2 <= '0;
                sb_in3 <= '0;
`endif
            end
            if (w_collect) r_col <= r_col + CNT_W'(1);
            // The final slice is merged on the fly so st_out* is already valid while done is high.
            if (w_last_col) begin
                st_out1 <= {sb_out1, w_rhi1};
                st_out2 <= {sb_out2, w_rhi2};
                st_out3 <= {sb_out3, w_rhi3};
            end
        end
    end

    share_shift_reg #(.OUT_LSB(0), .OUT_W(SLICE_W), .SELF_FILL(IN_SELF_FILL)) u_in1 (
        .clk(clk), .rst(rst), .i_clear(1'b0), .i_load(w_start_acc), .i_load_val(st_in1),
        .i_shift(w_xfer), .i_in_byte('0), .o_q(w_lo1));
    share_shift_reg #(.OUT_LSB(0), .OUT_W(SLICE_W), .SELF_FILL(IN_SELF_FILL)) u_in2 (
        .clk(clk), .rst(rst), .i_clear(1'b0), .i_load(w_start_acc), .i_load_val(st_in2),
        .i_shift(w_xfer), .i_in_byte('0), .o_q(w_lo2));
    share_shift_reg #(.OUT_LSB(0), .OUT_W(SLICE_W), .SELF_FILL(IN_SELF_FILL)) u_in3 (
        .clk(clk), .rst(rst), .i_clear(1'b0), .i_load(w_start_acc), .i_load_val(st_in3),
        .i_shift(w_xfer), .i_in_byte('0), .o_q(w_lo3));

    share_shift_reg #(.OUT_LSB(SLICE_W), .OUT_W(RHI_W), .SELF_FILL(1'b0)) u_res1 (
        .clk(clk), .rst(rst), .i_clear(w_res_clr), .i_load(1'b0), .i_load_val('0),
        .i_shift(w_collect), .i_in_byte(sb_out1), .o_q(w_rhi1));
    share_shift_reg #(.OUT_LSB(SLICE_W), .OUT_W(RHI_W), .SELF_FILL(1'b0)) u_res2 (
        .clk(clk), .rst(rst), .i_clear(w_res_clr), .i_load(1'b0), .i_load_val('0),
        .i_shift(w_collect), .i_in_byte(sb_out2), .o_q(w_rhi2));
    share_shift_reg #(.OUT_LSB(SLICE_W), .OUT_W(RHI_W), .SELF_FILL(1'b0)) u_res3 (
        .clk(clk), .rst(rst), .i_clear(w_res_clr), .i_load(1'b0), .i_load_val('0),
        .i_shift(w_collect), .i_in_byte(sb_out3), .o_q(w_rhi3));
endmodule
